// File: rtl/blft_pkg.sv
// Shared widths, FSM state encoding and the packed write-word payload for the
// pixel-to-word packer.
package blft_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned WADDR_W = ADDR_W - LANE_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [LANES-1:0]   be;
        logic [WORD_W-1:0]  data;
    } wword_t;

    // One-hot byte-enable for a lane index.
    function automatic logic [LANES-1:0] lane_bit(input logic [LANE_W-1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/blft_wfifo.sv
// Synchronous word FIFO whose head entry is presented through registered outputs.
module blft_wfifo
    import blft_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  wword_t i_push_word,
    output logic   o_valid,
    output wword_t o_word,
    input  logic   i_ready,
    output logic   o_empty_c,
    output logic   o_drop_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    wword_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    wword_t             r_word;

    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;
    logic [PTR_W-1:0]   w_rd_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    wword_t             w_head_nxt;

    // Next head: a word written on this edge bypasses memory when it becomes the head.
    always_comb begin
        w_pop      = r_valid && i_ready;
        w_full     = (r_count == CNT_W'(DEPTH));
        w_push_ok  = i_push && (!w_full || w_pop);
        o_drop_c   = i_push && w_full && !w_pop;
        w_rd_nxt   = w_pop ? PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;
        w_cnt_nxt  = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
        w_head_nxt = (w_push_ok && (r_wr_ptr == w_rd_nxt)) ? i_push_word : r_mem[w_rd_nxt];
        o_empty_c  = (r_count == '0);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_word   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_valid  <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) begin
                r_word <= w_head_nxt;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/blft_wpack.sv
// Packs filtered pixel writes into 32-bit byte-enabled memory words and signals
// end-of-frame once every packed word has been accepted.
module blft_wpack
    import blft_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [PIX_W-1:0]   in_data,
    input  logic               in_finish,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [WADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic [LANES-1:0]   wr_be,
    output logic               done,
    output logic               err
);

    localparam logic [LANES-1:0] ALL_LANES = {LANES{1'b1}};

    state_e               r_state;
    logic [WADDR_W-1:0]   r_pk_addr;
    logic [WORD_W-1:0]    r_pk_data;
    logic [LANES-1:0]     r_pk_be;
    logic                 r_done;
    logic                 r_err;

    state_e               w_state_nxt;
    logic [WADDR_W-1:0]   w_pk_addr_nxt;
    logic [WORD_W-1:0]    w_pk_data_nxt;
    logic [LANES-1:0]     w_pk_be_nxt;
    logic                 w_push;
    wword_t               w_push_word;
    logic                 w_pix_err;

    logic [LANE_W-1:0]    w_lane;
    logic [WADDR_W-1:0]   w_waddr;
    logic [LANES-1:0]     w_lane_be;
    logic [WORD_W-1:0]    w_lane_data;
    logic [WORD_W-1:0]    w_lane_mask;
    logic [WORD_W-1:0]    w_mrg_data;
    logic [LANES-1:0]     w_mrg_be;
    logic                 w_new_word;

    logic                 w_fifo_valid;
    wword_t               w_fifo_word;
    logic                 w_fifo_empty;
    logic                 w_fifo_drop;

    // Next state, pack update and FIFO push request.
    always_comb begin
        w_state_nxt   = r_state;
        w_pk_addr_nxt = r_pk_addr;
        w_pk_data_nxt = r_pk_data;
        w_pk_be_nxt   = r_pk_be;
        w_push        = 1'b0;
        w_push_word   = '{addr: r_pk_addr, be: r_pk_be, data: r_pk_data};
        w_pix_err     = 1'b0;

        w_lane      = in_addr[LANE_W-1:0];
        w_waddr     = in_addr[ADDR_W-1:LANE_W];
        w_lane_be   = lane_bit(w_lane);
        w_lane_data = WORD_W'(in_data) << {w_lane, 3'b000};
        w_lane_mask = WORD_W'({PIX_W{1'b1}}) << {w_lane, 3'b000};
        w_new_word  = (r_pk_be == '0) || (r_pk_addr != w_waddr);
        // A fresh word starts from zero so unwritten lanes never carry stale bytes.
        w_mrg_data  = ((w_new_word ? '0 : r_pk_data) & ~w_lane_mask) | w_lane_data;
        w_mrg_be    = (w_new_word ? '0 : r_pk_be) | w_lane_be;

        case (r_state)
            ST_RUN: begin
                if (in_valid) begin
                    if ((r_pk_be != '0) && (r_pk_addr != w_waddr)) begin
                        w_push = 1'b1;
                    end
                    if (w_mrg_be == ALL_LANES) begin
                        w_push      = 1'b1;
                        w_push_word = '{addr: w_waddr, be: w_mrg_be, data: w_mrg_data};
                        w_pk_be_nxt = '0;
                    end else begin
                        w_pk_addr_nxt = w_waddr;
                        w_pk_data_nxt = w_mrg_data;
                        w_pk_be_nxt   = w_mrg_be;
                    end
                end
                if (in_finish) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_pix_err   = in_valid;
                w_push      = (r_pk_be != '0);
                w_pk_be_nxt = '0;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_pix_err = in_valid;
                if (w_fifo_empty && !w_fifo_valid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_pix_err   = in_valid;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_pk_addr <= '0;
            r_pk_data <= '0;
            r_pk_be   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pk_addr <= w_pk_addr_nxt;
            r_pk_data <= w_pk_data_nxt;
            r_pk_be   <= w_pk_be_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_err     <= r_err | w_fifo_drop | w_pix_err;
        end
    end

    blft_wfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_word (w_push_word),
        .o_valid     (w_fifo_valid),
        .o_word      (w_fifo_word),
        .i_ready     (wr_ready),
        .o_empty_c   (w_fifo_empty),
        .o_drop_c    (w_fifo_drop)
    );

    assign wr_valid = w_fifo_valid;
    assign wr_addr  = w_fifo_word.addr;
    assign wr_data  = w_fifo_word.data;
    assign wr_be    = w_fifo_word.be;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_blft_wpack.sv
// Directed self-checking bench for the pixel-to-word packer.
module tb_blft_wpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        in_finish;
    logic        wr_valid;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    blft_wpack #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_finish (in_finish),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] a, input logic [7:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic fin();
        in_finish = 1'b1;
        step();
        in_finish = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [13:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        chk({tag, "_valid"}, 64'(wr_valid), 64'(1));
        chk({tag, "_addr"},  64'(wr_addr),  64'(a));
        chk({tag, "_be"},    64'(wr_be),    64'(be));
        chk({tag, "_data"},  64'(wr_data),  64'(d));
    endtask

    // Runs a bounded window, counting accepted writes and done pulses.
    task automatic wait_done(input string tag, input int exp_writes);
        int writes = 0;
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_valid && wr_ready) writes++;
            step();
            if (done) pulses++;
        end
        chk({tag, "_done_pulses"}, 64'(pulses), 64'(1));
        chk({tag, "_writes"},      64'(writes), 64'(exp_writes));
    endtask

    initial begin
        int          n_wr;
        logic [7:0]  b;
        logic [15:0] a;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_finish = 1'b0;
        wr_ready  = 1'b0;
        #12;
        chk("rst_wr_valid", 64'(wr_valid), 64'(0));
        chk("rst_wr_addr",  64'(wr_addr),  64'(0));
        chk("rst_wr_data",  64'(wr_data),  64'(0));
        chk("rst_wr_be",    64'(wr_be),    64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_err",      64'(err),      64'(0));
        @(negedge clk);
        rst = 1'b1;
        step();

        // Full word from four consecutive lanes
        wr_ready = 1'b1;
        pix(16'd0, 8'h11);
        pix(16'd1, 8'h22);
        pix(16'd2, 8'h33);
        chk("t1_pre_valid", 64'(wr_valid), 64'(0));
        pix(16'd3, 8'h44);
        chk_word("t1", 14'd0, 4'hF, 32'h44332211);
        step();
        chk("t1_post_valid", 64'(wr_valid), 64'(0));

        // Partial word pushed by an address change; next word held
        pix(16'd4,  8'haa);
        pix(16'd5,  8'hbb);
        pix(16'd12, 8'hcc);
        chk_word("t2", 14'd1, 4'h3, 32'h0000bbaa);
        step();
        chk("t2_hold_valid", 64'(wr_valid), 64'(0));
        fin();
        chk("t2_flush_pre_valid", 64'(wr_valid), 64'(0));
        step();
        chk_word("t2_flush", 14'd3, 4'h1, 32'h000000cc);
        wait_done("t2", 1);

        // Single pixel frame
        pix(16'h0101, 8'hab);
        fin();
        step();
        chk_word("t3", 14'h0040, 4'b0010, 32'h0000ab00);
        wait_done("t3", 1);

        // Overwrite of an already-set lane, last value wins
        pix(16'd8,  8'h01);
        pix(16'd8,  8'h02);
        pix(16'd9,  8'h03);
        pix(16'd10, 8'h04);
        pix(16'd11, 8'h05);
        chk_word("t4", 14'd2, 4'hF, 32'h05040302);
        step();

        // FIFO overflow: fifth full word dropped, then four writes in order
        wr_ready = 1'b0;
        for (int w = 4; w <= 8; w++) begin
            for (int l = 0; l < 4; l++) begin
                a = 16'(w * 4 + l);
                pix(a, a[7:0]);
            end
            if (w == 7) chk("t5_err_before_drop", 64'(err), 64'(0));
        end
        chk("t5_err_after_drop", 64'(err), 64'(1));
        chk_word("t5_head_stable", 14'd4, 4'hF, 32'h13121110);
        wr_ready = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_valid) begin
                b = 8'((4 + n_wr) * 4);
                chk("t5_order_addr", 64'(wr_addr), 64'(4 + n_wr));
                chk("t5_order_data", 64'(wr_data), 64'({8'(b + 3), 8'(b + 2), 8'(b + 1), b}));
                n_wr++;
            end
            step();
        end
        chk("t5_write_count", 64'(n_wr), 64'(4));
        chk("t5_err_sticky",  64'(err),  64'(1));

        // Reset during DRAIN discards the pending word
        wr_ready = 1'b0;
        pix(16'd64, 8'h77);
        fin();
        step();
        step();
        chk("t6_pending_valid", 64'(wr_valid), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_wr_valid", 64'(wr_valid), 64'(0));
        chk("t6_rst_done",     64'(done),     64'(0));
        chk("t6_rst_err",      64'(err),      64'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        wr_ready = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (wr_valid) n_wr++;
        end
        chk("t6_no_write_after_rst", 64'(n_wr), 64'(0));
        chk("t6_done_after_rst",     64'(done), 64'(0));

        // Empty flush, with a pixel arriving outside RUN
        fin();
        in_valid = 1'b1;
        in_addr  = 16'd0;
        in_data  = 8'hff;
        step();
        in_valid = 1'b0;
        chk("t7_err_pix_in_flush", 64'(err), 64'(1));
        wait_done("t7", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
